// File: rtl/mult_pkg.sv
// Shared state encoding and sizing helpers for the carry-save sequential multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int DEF_WIDTH = 24;
  localparam int DEF_BPC   = 2;

  // Counter width able to hold 0..WIDTH/BPC.
  function automatic int iter_w(input int width, input int bpc);
    return $clog2(width / bpc + 1);
  endfunction

endpackage

// File: rtl/csa_row.sv
// One row of independent full-adder cells: three W-bit operands reduced to sum and
// carry vectors. Carry is returned unshifted; its weight is one above its index.
module csa_row #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] s,
  output logic [W-1:0] c
);

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i] = x[i] ^ y[i] ^ z[i];
    assign c[i] = (x[i] & y[i]) | (x[i] & z[i]) | (y[i] & z[i]);
  end

endmodule

// File: rtl/csa_seq_mult.sv
// Iterative unsigned WIDTH x WIDTH multiplier. BPC partial products are folded into a
// redundant (sum, carry) accumulator per cycle; a single carry-propagate add closes out.
module csa_seq_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BPC   = DEF_BPC
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int ITERS  = WIDTH / BPC;
  localparam int ITER_W = iter_w(WIDTH, BPC);
  localparam int RW     = WIDTH + 2;
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(ITERS - 1);

  if (WIDTH < 4 || BPC < 1 || BPC > WIDTH || (WIDTH % BPC) != 0) begin : g_bad_params
    $error("csa_seq_mult: WIDTH must be >= 4 and BPC must divide WIDTH");
  end

  state_t              state_r;
  state_t              state_nx;
  logic [WIDTH-1:0]    a_r;
  logic [WIDTH-1:0]    b_r;
  logic [WIDTH:0]      sum_r;
  logic [WIDTH:0]      carry_r;
  logic [WIDTH-1:0]    plo_r;
  logic [ITER_W-1:0]   iter_r;
  logic [2*WIDTH-1:0]  p_r;
  logic                in_ready_r;
  logic                out_valid_r;
  logic                busy_r;

  logic                zero_op_s;
  logic [RW-1:0]       s_chain_s [BPC+1];
  logic [RW-1:0]       c_chain_s [BPC+1];
  logic [BPC-1:0]      ret_s;
  logic [WIDTH+BPC-1:0] plo_shift_s;
  logic [WIDTH:0]      cpa_s;
  logic                unused_s;

  assign zero_op_s = (a == {WIDTH{1'b0}}) || (b == {WIDTH{1'b0}});

  // Each row adds one partial product at weight 0, retires bit 0 and shifts the sum down;
  // the carry needs no shift because its implicit x2 cancels the divide by 2.
  assign s_chain_s[0] = {1'b0, sum_r};
  assign c_chain_s[0] = {1'b0, carry_r};

  for (genvar k = 0; k < BPC; k++) begin : g_rows
    logic [RW-1:0] pp_s;
    logic [RW-1:0] rs_s;
    logic [RW-1:0] rc_s;

    assign pp_s = b_r[k] ? {2'b00, a_r} : {RW{1'b0}};

    csa_row #(.W(RW)) u_row (
      .x (s_chain_s[k]),
      .y (c_chain_s[k]),
      .z (pp_s),
      .s (rs_s),
      .c (rc_s)
    );

    assign ret_s[k]         = rs_s[0];
    assign s_chain_s[k+1]   = {1'b0, rs_s[RW-1:1]};
    assign c_chain_s[k+1]   = rc_s;
  end

  assign plo_shift_s = {ret_s, plo_r} >> BPC;
  assign cpa_s       = sum_r + carry_r;

  // Row headroom bits are provably zero once the accumulator has been shifted down.
  assign unused_s = ^{s_chain_s[BPC][RW-1:WIDTH+1], c_chain_s[BPC][RW-1:WIDTH+1],
                      cpa_s[WIDTH], plo_shift_s[WIDTH+BPC-1:WIDTH]};

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          if (zero_op_s) begin
            state_nx = ST_DONE;
          end else begin
            state_nx = ST_BUSY;
          end
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (iter_r == LAST_ITER) begin
          state_nx = ST_RESOLVE;
        end else begin
          state_nx = ST_BUSY;
        end
      end
      ST_RESOLVE: state_nx = ST_DONE;
      ST_DONE: begin
        if (out_ready) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_DONE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Operand capture, accumulation, final resolve and registered handshake flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_r         <= '0;
      b_r         <= '0;
      sum_r       <= '0;
      carry_r     <= '0;
      plo_r       <= '0;
      iter_r      <= '0;
      p_r         <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      in_ready_r  <= (state_nx == ST_IDLE);
      out_valid_r <= (state_nx == ST_DONE);
      busy_r      <= (state_nx != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            a_r     <= a;
            b_r     <= b;
            sum_r   <= '0;
            carry_r <= '0;
            plo_r   <= '0;
            iter_r  <= '0;
            if (zero_op_s) begin
              p_r <= '0;
            end
          end
        end
        ST_BUSY: begin
          sum_r   <= s_chain_s[BPC][WIDTH:0];
          carry_r <= c_chain_s[BPC][WIDTH:0];
          plo_r   <= plo_shift_s[WIDTH-1:0];
          b_r     <= b_r >> BPC;
          iter_r  <= iter_r + ITER_W'(1);
        end
        ST_RESOLVE: p_r <= {cpa_s[WIDTH-1:0], plo_r};
        default: ;
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign p         = p_r;

endmodule

// File: tb/tb_csa_seq_mult.sv
// Directed and randomised checks of csa_seq_mult: main instance at BPC=2 plus
// side instances at other BPC values running random operands with output stalls.
module tb_csa_seq_mult;

  localparam int W  = 24;
  localparam int NB = 5;

  function automatic int bpc_of(input int i);
    case (i)
      0:       return 1;
      1:       return 3;
      2:       return 4;
      3:       return 6;
      default: return 24;
    endcase
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rstn;
  logic           rstn_aux;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] p;
  logic           busy;

  int checks    = 0;
  int errors    = 0;
  int rand_done = 0;

  csa_seq_mult #(.WIDTH(W), .BPC(2)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_before_accept", 64'(in_ready), 64'd1);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // lat counts edges from the accept edge (=1) up to the edge that raises out_valid.
  task automatic wait_valid(input int start, output int lat);
    lat = start;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
    int             lat;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int lat;
    int n;
    rstn = 1'b0; rstn_aux = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #12;
    check("reset_in_ready",  64'(in_ready),  64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_p",         64'(p),         64'd0);
    check("reset_busy",      64'(busy),      64'd0);
    @(negedge clk);
    rstn = 1'b1; rstn_aux = 1'b1;
    @(posedge clk); #1;

    vecs[0] = '{24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 14};
    vecs[1] = '{24'hC00000, 24'hA00000, 48'h780000000000, 14};
    vecs[2] = '{24'h800000, 24'h800000, 48'h400000000000, 14};
    vecs[3] = '{24'h000000, 24'h123456, 48'h000000000000, 1};
    vecs[4] = '{24'h123456, 24'h000000, 48'h000000000000, 1};
    vecs[5] = '{24'h000001, 24'hABCDEF, 48'h000000ABCDEF, 14};
    vecs[6] = '{24'h123456, 24'h000010, 48'h000001234560, 14};
    vecs[7] = '{24'h654321, 24'h000003, 48'h0000012FC963, 14};
    vecs[8] = '{24'h000002, 24'h800000, 48'h000001000000, 14};
    vecs[9] = '{24'h000003, 24'h000005, 48'h00000000000F, 14};

    for (int i = 0; i < 10; i++) begin
      start_op(vecs[i].a, vecs[i].b);
      wait_valid(1, lat);
      check("latency",       64'(lat),      64'(vecs[i].lat));
      check("product",       64'(p),        64'(vecs[i].p));
      check("in_ready_done", 64'(in_ready), 64'd0);
      handshake();
      check("out_valid_drop", 64'(out_valid), 64'd0);
      check("p_hold",         64'(p),         64'(vecs[i].p));
      check("in_ready_idle",  64'(in_ready),  64'd1);
    end

    // Stray in_valid and operand churn during BUSY, then a 5-cycle output stall.
    start_op(24'h00ABCD, 24'h000123);
    for (int i = 0; i < 6; i++) begin
      in_valid = i[0];
      a = W'($urandom);
      b = W'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_valid(7, lat);
    check("stall_latency", 64'(lat), 64'd14);
    for (int i = 0; i < 5; i++) begin
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_p",         64'(p),         64'h000000C34A07);
      check("stall_in_ready",  64'(in_ready),  64'd0);
      @(posedge clk); #1;
    end
    handshake();
    check("stall_release_valid", 64'(out_valid), 64'd0);
    check("stall_release_ready", 64'(in_ready),  64'd1);

    // Reset after five BUSY iterations abandons the operation.
    start_op(24'hFFFFFF, 24'h123456);
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("midbusy_busy", 64'(busy), 64'd1);
    rstn = 1'b0;
    #1;
    check("midrst_in_ready",  64'(in_ready),  64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_p",         64'(p),         64'd0);
    check("midrst_busy",      64'(busy),      64'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("midrst_no_output", 64'(out_valid), 64'd0);
    end
    start_op(24'h000003, 24'h000005);
    wait_valid(1, lat);
    check("post_rst_latency", 64'(lat), 64'd14);
    check("post_rst_product", 64'(p),   64'd15);
    handshake();

    n = 0;
    while (rand_done < NB && n < 20000) begin
      @(posedge clk);
      n++;
    end
    check("random_instances_done", 64'(rand_done), 64'(NB));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  for (genvar g = 0; g < NB; g++) begin : g_rand
    logic           r_in_valid;
    logic           r_in_ready;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic           r_out_valid;
    logic           r_out_ready;
    logic [2*W-1:0] r_p;
    logic           r_busy;

    csa_seq_mult #(.WIDTH(W), .BPC(bpc_of(g))) dut_r (
      .clk       (clk),
      .rstn      (rstn_aux),
      .in_valid  (r_in_valid),
      .in_ready  (r_in_ready),
      .a         (r_a),
      .b         (r_b),
      .out_valid (r_out_valid),
      .out_ready (r_out_ready),
      .p         (r_p),
      .busy      (r_busy)
    );

    initial begin
      logic [2*W-1:0] exp_p;
      int n;
      int stall;
      r_in_valid = 1'b0; r_out_ready = 1'b0; r_a = '0; r_b = '0;
      wait (rstn_aux === 1'b1);
      @(posedge clk); #1;
      for (int k = 0; k < 60; k++) begin
        r_a = W'($urandom);
        r_b = W'($urandom);
        if (k % 8 == 0) r_a = '0;
        if (k % 8 == 1) r_b = '0;
        if (k % 8 == 2) begin
          r_a = {W{1'b1}};
          r_b = {W{1'b1}};
        end
        exp_p = {24'd0, r_a} * {24'd0, r_b};
        n = 0;
        while (!r_in_ready && n < 50) begin
          @(posedge clk); #1;
          n++;
        end
        r_in_valid = 1'b1;
        @(posedge clk); #1;
        r_in_valid = 1'b0;
        n = 0;
        while (!r_out_valid && n < 200) begin
          @(posedge clk); #1;
          n++;
        end
        stall = int'($urandom_range(0, 3));
        repeat (stall) begin
          @(posedge clk); #1;
        end
        check($sformatf("rand_bpc%0d_valid", bpc_of(g)), 64'(r_out_valid), 64'd1);
        check($sformatf("rand_bpc%0d_p", bpc_of(g)), 64'(r_p), 64'(exp_p));
        r_out_ready = 1'b1;
        @(posedge clk); #1;
        r_out_ready = 1'b0;
        check($sformatf("rand_bpc%0d_no_dup", bpc_of(g)), 64'(r_out_valid), 64'd0);
      end
      rand_done++;
    end
  end

endmodule
